wb_video_arbiter: RTL and testbench

//  Shares the single Wishbone RAM port between two video masters: m0 = video_in writer, m1 = video_out reader.

---
 rtl/wb_video_arbiter.sv | 250 +++++++++++++++++++++++++
 tb/tb_wb_video_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_video_arbiter.sv
// ---------------------------------------------------------------------------
// wb_video_arbiter
// Shares one Wishbone RAM slave port between two video DMA masters:
//   m0 = video_in writer, m1 = video_out reader.
// Ownership is granted round-robin at cycle boundaries. LOCK lets an owner keep
// the bus across cycles, up to MAX_HOLD acknowledged beats while the other
// master waits. A watchdog ends any access the slave leaves unacknowledged for
// WD_CYCLES strobe cycles: it returns ERR and hands the bus on.
//
// Parameters
//   WD_CYCLES  strobe cycles without ACK before ERR is returned (>= 2)
//   MAX_HOLD   locked beats allowed while the other master requests (<= 63)
// Ports
//   clk, nRST                 clock, asynchronous active-low reset
//   m{0,1}_wb_*_I             master requests (CYC, STB, LOCK, WE, SEL, ADR, DAT)
//   m{0,1}_wb_DAT_O           slave read data, broadcast to both masters
//   m{0,1}_wb_ACK_O / ERR_O   acknowledge / watchdog error, owner only
//   s_wb_*_O                  owner's request muxed to the slave
//   s_wb_DAT_I, s_wb_ACK_I    slave read data and acknowledge
//   gnt                       one-hot owner (00 = idle)
// ---------------------------------------------------------------------------
module wb_video_arbiter #(
    parameter int WD_CYCLES = 64,
    parameter int MAX_HOLD  = 32
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic        m0_wb_CYC_I,
    input  logic        m0_wb_STB_I,
    input  logic        m0_wb_LOCK_I,
    input  logic        m0_wb_WE_I,
    input  logic [3:0]  m0_wb_SEL_I,
    input  logic [31:0] m0_wb_ADR_I,
    input  logic [31:0] m0_wb_DAT_I,
    output logic [31:0] m0_wb_DAT_O,
    output logic        m0_wb_ACK_O,
    output logic        m0_wb_ERR_O,
    input  logic        m1_wb_CYC_I,
    input  logic        m1_wb_STB_I,
    input  logic        m1_wb_LOCK_I,
    input  logic        m1_wb_WE_I,
    input  logic [3:0]  m1_wb_SEL_I,
    input  logic [31:0] m1_wb_ADR_I,
    input  logic [31:0] m1_wb_DAT_I,
    output logic [31:0] m1_wb_DAT_O,
    output logic        m1_wb_ACK_O,
    output logic        m1_wb_ERR_O,
    output logic        s_wb_CYC_O,
    output logic        s_wb_STB_O,
    output logic        s_wb_WE_O,
    output logic [3:0]  s_wb_SEL_O,
    output logic [31:0] s_wb_ADR_O,
    output logic [31:0] s_wb_DAT_O,
    input  logic [31:0] s_wb_DAT_I,
    input  logic        s_wb_ACK_I,
    output logic [1:0]  gnt
);

    localparam int              WD_W     = $clog2(WD_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(WD_CYCLES - 1);
    localparam logic [5:0]      HOLD_LIM = 6'(MAX_HOLD);
    localparam logic [5:0]      HOLD_SAT = 6'd63;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } state_t;

    state_t          state_r;
    state_t          nxt_state_s;
    logic            last_r;        // 1: m1 was the last owner, so m0 wins a tie
    logic            nxt_last_s;
    logic [1:0]      gnt_r;
    logic [5:0]      hold_r;
    logic [5:0]      nxt_hold_s;
    logic [WD_W-1:0] wd_r;
    logic [WD_W-1:0] nxt_wd_s;
    logic            block_r;       // slave CYC/STB blanked the cycle after a timeout

    logic            own0_s;
    logic            own1_s;
    logic            own_cyc_s;
    logic            own_stb_s;
    logic            own_lock_s;
    logic            oth_cyc_s;
    logic            ack_s;
    logic            timeout_s;
    logic            release_s;
    logic            end_s;

    assign gnt = gnt_r;

    // Select the current owner's control inputs and the other master's request
    always_comb begin
        own0_s     = (state_r == ST_OWN0);
        own1_s     = (state_r == ST_OWN1);
        own_cyc_s  = 1'b0;
        own_stb_s  = 1'b0;
        own_lock_s = 1'b0;
        oth_cyc_s  = 1'b0;
        if (own0_s) begin
            own_cyc_s  = m0_wb_CYC_I;
            own_stb_s  = m0_wb_STB_I;
            own_lock_s = m0_wb_LOCK_I;
            oth_cyc_s  = m1_wb_CYC_I;
        end else if (own1_s) begin
            own_cyc_s  = m1_wb_CYC_I;
            own_stb_s  = m1_wb_STB_I;
            own_lock_s = m1_wb_LOCK_I;
            oth_cyc_s  = m0_wb_CYC_I;
        end else begin
            own_cyc_s  = 1'b0;
        end
    end

    // ACK beats the watchdog when both land in the same cycle
    assign ack_s     = s_wb_ACK_I & own_stb_s;
    assign timeout_s = own_stb_s & ~block_r & ~s_wb_ACK_I & (wd_r == WD_LAST);
    // A locked owner between cycles gives way only once it has used its beats
    assign release_s = ~own_cyc_s &
                       (~own_lock_s | ((hold_r >= HOLD_LIM) & oth_cyc_s));
    assign end_s     = timeout_s | release_s;

    // Next owner: round-robin from idle, hand-over without an idle bubble
    always_comb begin
        nxt_state_s = state_r;
        nxt_last_s  = last_r;
        case (state_r)
            ST_IDLE: begin
                if (m0_wb_CYC_I && m1_wb_CYC_I) begin
                    nxt_state_s = last_r ? ST_OWN0 : ST_OWN1;
                end else if (m0_wb_CYC_I) begin
                    nxt_state_s = ST_OWN0;
                end else if (m1_wb_CYC_I) begin
                    nxt_state_s = ST_OWN1;
                end else begin
                    nxt_state_s = ST_IDLE;
                end
            end
            ST_OWN0: begin
                if (end_s) begin
                    nxt_last_s  = 1'b0;
                    nxt_state_s = m1_wb_CYC_I ? ST_OWN1 : ST_IDLE;
                end else begin
                    nxt_state_s = ST_OWN0;
                end
            end
            ST_OWN1: begin
                if (end_s) begin
                    nxt_last_s  = 1'b1;
                    nxt_state_s = m0_wb_CYC_I ? ST_OWN0 : ST_IDLE;
                end else begin
                    nxt_state_s = ST_OWN1;
                end
            end
            default: begin
                nxt_state_s = ST_IDLE;
            end
        endcase
    end

    // Lock-beat and watchdog counters; both restart whenever ownership changes
    always_comb begin
        nxt_hold_s = 6'd0;
        nxt_wd_s   = '0;
        if ((own0_s || own1_s) && !end_s) begin
            if (!own_lock_s) begin
                nxt_hold_s = 6'd0;
            end else if (ack_s && (hold_r != HOLD_SAT)) begin
                nxt_hold_s = hold_r + 6'd1;
            end else begin
                nxt_hold_s = hold_r;
            end
            if (own_stb_s && !block_r && !ack_s) begin
                nxt_wd_s = wd_r + WD_W'(1);
            end else begin
                nxt_wd_s = '0;
            end
        end else begin
            nxt_hold_s = 6'd0;
        end
    end

    // Arbitration state register with registered grant
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_r <= ST_IDLE;
            gnt_r   <= 2'b00;
            last_r  <= 1'b1;
            hold_r  <= 6'd0;
            wd_r    <= '0;
            block_r <= 1'b0;
        end else begin
            state_r <= nxt_state_s;
            last_r  <= nxt_last_s;
            hold_r  <= nxt_hold_s;
            wd_r    <= nxt_wd_s;
            block_r <= timeout_s;
            case (nxt_state_s)
                ST_OWN0: gnt_r <= 2'b01;
                ST_OWN1: gnt_r <= 2'b10;
                default: gnt_r <= 2'b00;
            endcase
        end
    end

    // Route the owner's request to the slave and the slave response back
    always_comb begin
        s_wb_CYC_O  = 1'b0;
        s_wb_STB_O  = 1'b0;
        s_wb_WE_O   = 1'b0;
        s_wb_SEL_O  = 4'd0;
        s_wb_ADR_O  = 32'd0;
        s_wb_DAT_O  = 32'd0;
        m0_wb_ACK_O = 1'b0;
        m1_wb_ACK_O = 1'b0;
        m0_wb_ERR_O = 1'b0;
        m1_wb_ERR_O = 1'b0;
        if (own0_s) begin
            s_wb_WE_O   = m0_wb_WE_I;
            s_wb_SEL_O  = m0_wb_SEL_I;
            s_wb_ADR_O  = m0_wb_ADR_I;
            s_wb_DAT_O  = m0_wb_DAT_I;
            m0_wb_ACK_O = ack_s;
            m0_wb_ERR_O = timeout_s;
        end else if (own1_s) begin
            s_wb_WE_O   = m1_wb_WE_I;
            s_wb_SEL_O  = m1_wb_SEL_I;
            s_wb_ADR_O  = m1_wb_ADR_I;
            s_wb_DAT_O  = m1_wb_DAT_I;
            m1_wb_ACK_O = ack_s;
            m1_wb_ERR_O = timeout_s;
        end else begin
            s_wb_WE_O   = 1'b0;
        end
        // Timed-out access is dropped at the slave now and for one more cycle
        if (!timeout_s && !block_r) begin
            s_wb_CYC_O = own_cyc_s;
            s_wb_STB_O = own_stb_s;
        end else begin
            s_wb_CYC_O = 1'b0;
            s_wb_STB_O = 1'b0;
        end
    end

    assign m0_wb_DAT_O = s_wb_DAT_I;
    assign m1_wb_DAT_O = s_wb_DAT_I;

endmodule

// File: tb/tb_wb_video_arbiter.sv
module tb_wb_video_arbiter;

    localparam int WD = 64;
    localparam int MH = 32;

    logic        clk = 1'b0;
    logic        nRST = 1'b0;
    logic        m0_cyc = 1'b0, m0_stb = 1'b0, m0_lock = 1'b0, m0_we = 1'b0;
    logic [3:0]  m0_sel = 4'd0;
    logic [31:0] m0_adr = 32'd0, m0_dat = 32'd0;
    logic        m1_cyc = 1'b0, m1_stb = 1'b0, m1_lock = 1'b0, m1_we = 1'b0;
    logic [3:0]  m1_sel = 4'd0;
    logic [31:0] m1_adr = 32'd0, m1_dat = 32'd0;
    logic [31:0] s_dat_i = 32'd0;
    logic        s_ack = 1'b0;
    logic [31:0] m0_dat_o, m1_dat_o, s_adr, s_dat_o;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic        s_cyc, s_stb, s_we;
    logic [3:0]  s_sel;
    logic [1:0]  gnt;

    wb_video_arbiter #(.WD_CYCLES(WD), .MAX_HOLD(MH)) dut (
        .clk(clk), .nRST(nRST),
        .m0_wb_CYC_I(m0_cyc), .m0_wb_STB_I(m0_stb), .m0_wb_LOCK_I(m0_lock),
        .m0_wb_WE_I(m0_we), .m0_wb_SEL_I(m0_sel), .m0_wb_ADR_I(m0_adr),
        .m0_wb_DAT_I(m0_dat), .m0_wb_DAT_O(m0_dat_o), .m0_wb_ACK_O(m0_ack),
        .m0_wb_ERR_O(m0_err),
        .m1_wb_CYC_I(m1_cyc), .m1_wb_STB_I(m1_stb), .m1_wb_LOCK_I(m1_lock),
        .m1_wb_WE_I(m1_we), .m1_wb_SEL_I(m1_sel), .m1_wb_ADR_I(m1_adr),
        .m1_wb_DAT_I(m1_dat), .m1_wb_DAT_O(m1_dat_o), .m1_wb_ACK_O(m1_ack),
        .m1_wb_ERR_O(m1_err),
        .s_wb_CYC_O(s_cyc), .s_wb_STB_O(s_stb), .s_wb_WE_O(s_we),
        .s_wb_SEL_O(s_sel), .s_wb_ADR_O(s_adr), .s_wb_DAT_O(s_dat_o),
        .s_wb_DAT_I(s_dat_i), .s_wb_ACK_I(s_ack), .gnt(gnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: who owns the bus and the bookkeeping the rules need
    int mo_owner = -1;   // -1 nobody, else master index
    int mo_last  = 1;    // master that ended the most recent ownership
    int mo_hold  = 0;    // ACKed beats taken under lock
    int mo_stall = 0;    // strobe cycles waited without ACK
    bit mo_black = 1'b0; // cycle after a watchdog abort

    // Observed event counters
    int ack0_n, ack1_n, err0_n, err1_n, stb0_n, err0_at;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mo_reset();
        mo_owner = -1; mo_last = 1; mo_hold = 0; mo_stall = 0; mo_black = 1'b0;
    endtask

    task automatic clr_counts();
        ack0_n = 0; ack1_n = 0; err0_n = 0; err1_n = 0; stb0_n = 0; err0_at = 0;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance it
    task automatic tick();
        int o, other;
        bit ocyc, ostb, olock, owe, oth_cyc, ack_e, tmo_e, gone;
        logic [3:0]  osel;
        logic [31:0] oadr, odat;
        @(negedge clk);
        o = mo_owner;
        other = 1 - o;
        ocyc = 1'b0; ostb = 1'b0; olock = 1'b0; owe = 1'b0; oth_cyc = 1'b0;
        osel = 4'd0; oadr = 32'd0; odat = 32'd0;
        if (o == 0) begin
            ocyc = m0_cyc; ostb = m0_stb; olock = m0_lock; owe = m0_we;
            osel = m0_sel; oadr = m0_adr; odat = m0_dat; oth_cyc = m1_cyc;
        end else if (o == 1) begin
            ocyc = m1_cyc; ostb = m1_stb; olock = m1_lock; owe = m1_we;
            osel = m1_sel; oadr = m1_adr; odat = m1_dat; oth_cyc = m0_cyc;
        end
        ack_e = ostb && s_ack;
        tmo_e = ostb && !s_ack && !mo_black && (mo_stall == WD - 1);

        chk("gnt", gnt, (o == 0) ? 2'b01 : (o == 1) ? 2'b10 : 2'b00);
        chk("s_cyc", s_cyc, ocyc && !tmo_e && !mo_black);
        chk("s_stb", s_stb, ostb && !tmo_e && !mo_black);
        chk("s_we", s_we, owe);
        chk("s_sel", s_sel, osel);
        chk("s_adr", s_adr, oadr);
        chk("s_dat", s_dat_o, odat);
        chk("m0_ack", m0_ack, (o == 0) && ack_e);
        chk("m1_ack", m1_ack, (o == 1) && ack_e);
        chk("m0_err", m0_err, (o == 0) && tmo_e);
        chk("m1_err", m1_err, (o == 1) && tmo_e);
        chk("rdata", {m0_dat_o, m1_dat_o}, {s_dat_i, s_dat_i});

        if (m0_ack) ack0_n++;
        if (m1_ack) ack1_n++;
        if (gnt == 2'b01 && m0_stb) stb0_n++;
        if (m0_err) begin err0_n++; err0_at = stb0_n; end
        if (m1_err) err1_n++;

        @(posedge clk);
        #1;
        if (!nRST) begin
            mo_reset();
        end else if (o < 0) begin
            if (m0_cyc && m1_cyc) mo_owner = 1 - mo_last;
            else if (m0_cyc)      mo_owner = 0;
            else if (m1_cyc)      mo_owner = 1;
            else                  mo_owner = -1;
            mo_hold = 0; mo_stall = 0; mo_black = 1'b0;
        end else begin
            gone = tmo_e || (!ocyc && (!olock || (mo_hold >= MH && oth_cyc)));
            if (gone) begin
                mo_last  = o;
                mo_owner = oth_cyc ? other : -1;
                mo_hold  = 0;
                mo_stall = 0;
            end else begin
                if (!olock) mo_hold = 0;
                else if (ack_e && mo_hold < 63) mo_hold = mo_hold + 1;
                mo_stall = (ostb && !mo_black && !ack_e) ? mo_stall + 1 : 0;
            end
            mo_black = tmo_e;
        end
    endtask

    task automatic do_reset();
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_lock = 1'b0;
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_lock = 1'b0;
        s_ack = 1'b0;
        nRST = 1'b0;
        mo_reset();
        tick();
        tick();
        nRST = 1'b1;
        clr_counts();
    endtask

    int ack_rate;

    initial begin
        clr_counts();
        // Outputs idle while reset is held, even with requests present
        m0_cyc = 1'b1; m0_stb = 1'b1; s_ack = 1'b1;
        tick();
        chk("rst_cyc", s_cyc, 1'b0);
        chk("rst_ack", m0_ack, 1'b0);

        // 1: single master, slave ACKs on the fourth owned cycle
        do_reset();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_adr = 32'h0000_0100;
        m0_sel = 4'hF; m0_dat = 32'hCAFE_0001;
        tick();
        chk("t1_gnt", gnt, 2'b01);
        chk("t1_adr", s_adr, 32'h0000_0100);
        tick(); tick(); tick();
        s_ack = 1'b1;
        tick();
        chk("t1_ack0", ack0_n, 1);
        chk("t1_ack1", ack1_n, 0);
        m0_cyc = 1'b0; m0_stb = 1'b0; s_ack = 1'b0;
        tick();

        // 2: tie after reset goes to m0, then hand-over with no idle bubble
        do_reset();
        m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
        m1_adr = 32'h0000_2000;
        tick();
        chk("t2_first", gnt, 2'b01);
        s_ack = 1'b1;
        tick();
        m0_cyc = 1'b0; m0_stb = 1'b0; s_ack = 1'b0;
        tick();
        chk("t2_switch", gnt, 2'b10);
        s_ack = 1'b1;
        tick();
        m1_cyc = 1'b0; m1_stb = 1'b0; s_ack = 1'b0;
        tick();

        // 3: locked m1 gets MAX_HOLD beats, then m0 takes over
        do_reset();
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_lock = 1'b1;
        tick();
        m0_cyc = 1'b1; m0_stb = 1'b1;
        for (int i = 0; i < 40; i++) begin
            m1_cyc = 1'b1; m1_stb = 1'b1; s_ack = 1'b1;
            tick();
            m1_cyc = 1'b0; m1_stb = 1'b0; s_ack = 1'b0;
            tick();
            if (gnt == 2'b01) break;
        end
        chk("t3_beats", ack1_n, MH);
        chk("t3_gnt", gnt, 2'b01);
        m1_lock = 1'b0; s_ack = 1'b1;
        tick();
        m0_cyc = 1'b0; m0_stb = 1'b0; s_ack = 1'b0;
        tick();

        // 4: slave never ACKs -> ERR on the WD-th strobe cycle, bus moves on
        do_reset();
        m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (err0_n > 0) break;
        end
        chk("t4_err_at", err0_at, WD);
        chk("t4_gnt", gnt, 2'b10);
        chk("t4_err1", err1_n, 0);
        m0_cyc = 1'b0; m0_stb = 1'b0;
        tick();
        s_ack = 1'b1;
        tick();
        m1_cyc = 1'b0; m1_stb = 1'b0; s_ack = 1'b0;
        tick();

        // 5: ACK on the last watchdog cycle wins over ERR
        do_reset();
        m0_cyc = 1'b1; m0_stb = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (stb0_n >= WD - 1) break;
            tick();
        end
        s_ack = 1'b1;
        tick();
        chk("t5_err", err0_n, 0);
        chk("t5_ack", ack0_n, 1);
        chk("t5_cnt", stb0_n, WD);
        s_ack = 1'b0;
        tick();
        chk("t5_keep", gnt, 2'b01);
        m0_cyc = 1'b0; m0_stb = 1'b0;
        tick();

        // 6: asynchronous reset mid-transfer drops the bus at once
        do_reset();
        m0_cyc = 1'b1; m0_stb = 1'b1;
        tick();
        tick();
        chk("t6_pre", s_cyc, 1'b1);
        #2;
        nRST = 1'b0;
        #1;
        mo_reset();
        chk("t6_cyc", s_cyc, 1'b0);
        chk("t6_gnt", gnt, 2'b00);
        m1_cyc = 1'b1; m1_stb = 1'b1;
        tick();
        nRST = 1'b1;
        tick();
        chk("t6_tie", gnt, 2'b01);
        m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        tick();

        // Random traffic against the model, with varying slave responsiveness
        do_reset();
        ack_rate = 4;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                case ($urandom_range(0, 3))
                    0: ack_rate = 0;
                    1: ack_rate = 2;
                    2: ack_rate = 4;
                    default: ack_rate = 7;
                endcase
            end
            if ($urandom_range(0, 7) == 0) m0_cyc = ~m0_cyc;
            if ($urandom_range(0, 7) == 0) m1_cyc = ~m1_cyc;
            if ($urandom_range(0, 15) == 0) m0_lock = ~m0_lock;
            if ($urandom_range(0, 15) == 0) m1_lock = ~m1_lock;
            m0_stb = m0_cyc & ($urandom_range(0, 3) != 0);
            m1_stb = m1_cyc & ($urandom_range(0, 3) != 0);
            m0_we = 1'($urandom_range(0, 1)); m1_we = 1'($urandom_range(0, 1));
            m0_sel = 4'($urandom); m1_sel = 4'($urandom);
            m0_adr = $urandom; m1_adr = $urandom;
            m0_dat = $urandom; m1_dat = $urandom;
            s_dat_i = $urandom;
            s_ack = ($urandom_range(0, 7) < ack_rate);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
